// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous SPI pin, followed by registered rise/fall pulses.
// Reset value is chosen per pin so that reset itself never produces an edge.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic aclk,
  input  logic areset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  // Delayed level lines up with the registered edge pulses.
  assign level = prev_q;

endmodule

// File: rtl/axis_spi_slave.sv
// SPI mode-0 slave bridging 8-bit words to AXI-Stream, clocked entirely by aclk.
// One-byte transmit holding register; one-byte receive output register with overrun drop.
module axis_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_DATA   = 8'h00
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       SCK_I,
  input  logic       SS_I,
  input  logic       IO0_I,
  output logic       IO1_O,
  output logic       IO1_T,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       tx_underrun,
  output logic       rx_overrun
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q;
  logic [7:0] tx_shift_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       load_pend_q;
  logic       rst_q;

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic s_fire, word_load;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .aclk   (aclk),
    .areset (areset),
    .din    (SCK_I),
    .level  (sck_level),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .aclk   (aclk),
    .areset (areset),
    .din    (SS_I),
    .level  (ss_level),
    .rise   (ss_rise),
    .fall   (ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .aclk   (aclk),
    .areset (areset),
    .din    (IO0_I),
    .level  (mosi_level),
    .rise   (mosi_rise),
    .fall   (mosi_fall)
  );

  assign unused_edges  = ^{sck_level, ss_level, mosi_rise, mosi_fall};

  assign s_axis_tready = ~hold_full_q & ~rst_q;
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign IO1_O         = tx_shift_q[7];

  // SS rise wins over a coincident SCK fall, so a transfer ending on the last fall loads nothing.
  always_comb begin
    word_load = 1'b0;
    if (state_q == StIdle) begin
      word_load = ss_fall;
    end else begin
      word_load = ~ss_rise & sck_fall & load_pend_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      load_pend_q   <= 1'b0;
      rst_q         <= 1'b1;
      IO1_T         <= 1'b1;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      tx_underrun   <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rst_q       <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      // A fill in the same cycle as a load lands after the load took the old state.
      if (s_fire) begin
        hold_q      <= s_axis_tdata;
        hold_full_q <= 1'b1;
      end else if (word_load) begin
        hold_full_q <= 1'b0;
      end

      if (word_load) begin
        tx_shift_q  <= hold_full_q ? hold_q : IDLE_DATA;
        tx_underrun <= ~hold_full_q;
        load_pend_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q   <= StActive;
            IO1_T     <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        StActive: begin
          if (ss_rise) begin
            state_q     <= StIdle;
            IO1_T       <= 1'b1;
            bit_cnt_q   <= '0;
            load_pend_q <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_shift_q <= {rx_shift_q[6:0], mosi_level};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                load_pend_q <= 1'b1;
                if (!m_axis_tvalid || m_axis_tready) begin
                  m_axis_tdata  <= {rx_shift_q[6:0], mosi_level};
                  m_axis_tvalid <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;
                end
              end
            end
            if (sck_fall && !load_pend_q) tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_spi_slave.sv
// Bench: mode-0 SPI master at aclk/16 with a queue-based model of the tx holding byte and rx path.
module tb_axis_spi_slave;

  localparam int         HALF = 8;
  localparam logic [7:0] IDLE = 8'h00;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       SCK_I = 1'b0;
  logic       SS_I = 1'b1;
  logic       IO0_I = 1'b0;
  logic       IO1_O, IO1_T;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       tx_underrun, rx_overrun;

  always #5 aclk = ~aclk;

  axis_spi_slave #(.SYNC_STAGES(2), .IDLE_DATA(IDLE)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .SCK_I         (SCK_I),
    .SS_I          (SS_I),
    .IO0_I         (IO0_I),
    .IO1_O         (IO1_O),
    .IO1_T         (IO1_T),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .tx_underrun   (tx_underrun),
    .rx_overrun    (rx_overrun)
  );

  int n_checks = 0;
  int n_fail = 0;
  int underruns = 0;
  int overruns = 0;
  int exp_underruns = 0;
  int exp_overruns = 0;
  int tready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

  logic [7:0] feed_q[$];    // bytes waiting to be offered on s_axis
  logic [7:0] tx_model[$];  // bytes accepted into the slave, in order
  logic [7:0] exp_rx[$];    // bytes the slave should deliver on m_axis

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // s_axis driver
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    forever begin
      @(posedge aclk);
      #1;
      if (feed_q.size() != 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = feed_q[0];
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  end

  // m_axis_tready driver
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every m_axis beat, counts pulses, records s_axis accepts.
  initial begin
    logic [7:0] prev_data;
    logic       prev_stall;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge aclk);
      if (areset !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (tx_underrun === 1'b1) underruns++;
        if (rx_overrun === 1'b1) overruns++;
        if (prev_stall && m_axis_tvalid === 1'b1)
          check("m_axis_stable", 32'(m_axis_tdata), 32'(prev_data));
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
          if (exp_rx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL m_axis_unexpected: got beat %0h, expected none", m_axis_tdata);
          end else begin
            e = exp_rx.pop_front();
            check("m_axis_tdata", 32'(m_axis_tdata), 32'(e));
          end
        end
        prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (s_axis_tvalid && s_axis_tready === 1'b1) begin
          tx_model.push_back(s_axis_tdata);
          void'(feed_q.pop_front());
        end
      end
    end
  end

  task automatic preload(input logic [7:0] b);
    int t;
    feed_q.push_back(b);
    t = 0;
    while (feed_q.size() != 0 && t < 100) begin
      wait_clks(1);
      t++;
    end
    check("preload_accepted", 32'(feed_q.size()), 32'd0);
    wait_clks(2);
  endtask

  // Mode-0 master: data set while SCK low, MISO sampled at SCK rise. The final SCK fall
  // coincides with SS rise unless keep_ss is set.
  task automatic spi_xfer(input logic [7:0] words[$], input int last_bits, input bit keep_ss);
    logic [7:0] rx;
    logic [7:0] exp_miso;
    int         nb;
    SS_I = 1'b0;
    for (int w = 0; w < words.size(); w++) begin
      if (tx_model.size() != 0) begin
        exp_miso = tx_model.pop_front();
      end else begin
        exp_miso = IDLE;
        exp_underruns++;
      end
      nb = (w == words.size() - 1) ? last_bits : 8;
      if (nb == 8) begin
        if (tready_mode == 0 && exp_rx.size() != 0) exp_overruns++;
        else exp_rx.push_back(words[w]);
      end
      rx = 8'h00;
      for (int i = 7; i >= 8 - nb; i--) begin
        IO0_I = words[w][i];
        wait_clks(HALF);
        SCK_I = 1'b1;
        rx[i] = IO1_O;
        if (i == 7 && w == 0) check("io1_t_active", 32'(IO1_T), 32'd0);
        wait_clks(HALF);
        SCK_I = 1'b0;
        if (w == words.size() - 1 && i == 8 - nb && !keep_ss) SS_I = 1'b1;
      end
      if (nb == 8) check("miso_byte", 32'(rx), 32'(exp_miso));
    end
    wait_clks(2 * HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_io1_t"}, 32'(IO1_T), 32'd1);
    check({tag, "_io1_o"}, 32'(IO1_O), 32'd0);
    check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
    check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
    check({tag, "_overrun"}, 32'(rx_overrun), 32'd0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_rx.size() != 0 && t < 2000) begin
      wait_clks(1);
      t++;
    end
    check("rx_drained", 32'(exp_rx.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] wq[$];
    int         nw, k;

    // Reset values
    wait_clks(3);
    check_reset_outputs("reset");
    areset = 1'b0;
    wait_clks(1);
    check("tready_after_reset", 32'(s_axis_tready), 32'd1);
    wait_clks(4);

    // Preloaded byte out, master byte in
    preload(8'hA5);
    wq.delete(); wq.push_back(8'h55);
    spi_xfer(wq, 8, 1'b0);
    check("idle_io1_t", 32'(IO1_T), 32'd1);
    wait_drain();

    // Empty holding register
    wq.delete(); wq.push_back(8'h3C);
    spi_xfer(wq, 8, 1'b0);
    wait_drain();
    check("underrun_count_single", 32'(underruns), 32'(exp_underruns));

    // Three words under one SS
    preload(8'h11);
    feed_q.push_back(8'h22);
    feed_q.push_back(8'h33);
    wq.delete(); wq.push_back(8'hC1); wq.push_back(8'hC2); wq.push_back(8'hC3);
    spi_xfer(wq, 8, 1'b0);
    wait_drain();
    check("underrun_count_b2b", 32'(underruns), 32'(exp_underruns));

    // Overrun with tready held low
    tready_mode = 0;
    wq.delete(); wq.push_back(8'hAA); wq.push_back(8'hBB);
    spi_xfer(wq, 8, 1'b0);
    check("ovr_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    check("ovr_tdata_held", 32'(m_axis_tdata), 32'hAA);
    check("overrun_count", 32'(overruns), 32'(exp_overruns));
    tready_mode = 1;
    wait_drain();

    // SS raised mid-word
    wq.delete(); wq.push_back(8'hF0);
    spi_xfer(wq, 5, 1'b0);
    check("abort_io1_t", 32'(IO1_T), 32'd1);
    check("abort_no_beat", 32'(m_axis_tvalid), 32'd0);
    wq.delete(); wq.push_back(8'h0F);
    spi_xfer(wq, 8, 1'b0);
    wait_drain();

    // Reset mid-word; master releases SS while reset is held
    wq.delete(); wq.push_back(8'h7E);
    spi_xfer(wq, 3, 1'b1);
    areset = 1'b1;
    SS_I   = 1'b1;
    wait_clks(1);
    check_reset_outputs("midreset");
    wait_clks(4);
    areset = 1'b0;
    tx_model.delete();
    wait_clks(2 * HALF);
    wq.delete(); wq.push_back(8'h81);
    spi_xfer(wq, 8, 1'b0);
    wait_drain();
    check("underrun_count_reset", 32'(underruns), 32'(exp_underruns));

    // Randomised transfers with random backpressure
    tready_mode = 2;
    for (int it = 0; it < 16; it++) begin
      nw = int'($urandom_range(1, 3));
      k  = int'($urandom_range(0, nw));
      if (k > 0) preload(8'($urandom));
      for (int j = 1; j < k; j++) feed_q.push_back(8'($urandom));
      wq.delete();
      for (int j = 0; j < nw; j++) wq.push_back(8'($urandom));
      spi_xfer(wq, 8, 1'b0);
    end
    tready_mode = 1;
    wait_drain();
    check("underrun_count_final", 32'(underruns), 32'(exp_underruns));
    check("overrun_count_final", 32'(overruns), 32'(exp_overruns));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_spi_slave.md
AXIS_SPI_SLAVE -- requirements
Module: axis_spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth (2..4) on SCK_I, SS_I and IO0_I.
REQ-002 Parameter IDLE_DATA, default 8'h00: byte shifted out on MISO when no transmit byte is held.
REQ-003 Port aclk, input, 1: single clock; all logic rising-edge.
REQ-004 Port areset, input, 1: synchronous, active-high reset.
REQ-005 Port SCK_I, input, 1: SPI clock from master, asynchronous.
REQ-006 Port SS_I, input, 1: slave select, active-low, asynchronous.
REQ-007 Port IO0_I, input, 1: MOSI, asynchronous.
REQ-008 Port IO1_O, output, 1: MISO data.
REQ-009 Port IO1_T, output, 1: MISO tristate control, 1 = high-Z.
REQ-010 Ports s_axis_tdata (input, 8), s_axis_tvalid (input, 1), s_axis_tready (output, 1): transmit bytes.
REQ-011 Ports m_axis_tdata (output, 8), m_axis_tvalid (output, 1), m_axis_tready (input, 1): received bytes.
REQ-012 Ports tx_underrun and rx_overrun, output, 1 each: single-cycle error pulses.

Function
REQ-013 SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit words, fixed.
REQ-014 SCK_I, SS_I and IO0_I each pass through SYNC_STAGES flops, then one edge-detect flop; all SPI events are acted on in aclk.
REQ-015 Supported SCK rate: SCK high and low times each >= SYNC_STAGES+2 aclk periods, i.e. SCK <= aclk/8 with defaults.
REQ-016 States: IDLE (SS high), ACTIVE (SS low, shifting); IDLE->ACTIVE on synchronised SS fall; ACTIVE->IDLE on synchronised SS rise.
REQ-017 IO1_T = 1 in IDLE; IO1_T = 0 in ACTIVE.
REQ-018 Master requirement: SS fall to first SCK rise >= SYNC_STAGES+3 aclk periods.
REQ-019 Transmit holding register, 1 byte: s_axis_tready = 1 when empty; a beat with tvalid && tready fills it.
REQ-020 Word load: on IDLE->ACTIVE, and on the first SCK fall after the 8th SCK rise of a word: the TX shifter takes the holding byte (holding register then empty) or IDLE_DATA if empty, which also pulses tx_underrun for one cycle.
REQ-021 IO1_O = TX shifter bit 7 at all times; the shifter shifts left by one on each SCK fall that is not a word load.
REQ-022 On each SCK rise, IO0_I is shifted into the RX shifter LSB and the 3-bit bit counter increments, wrapping 7->0.
REQ-023 On the 8th rise (counter 7->0), the RX byte is presented: if m_axis_tvalid = 0, or it is 1 with m_axis_tready = 1 in the same cycle, then m_axis_tdata <= byte and m_axis_tvalid <= 1 on the next cycle.
REQ-024 Otherwise the new byte is dropped, the pending m_axis_tdata is kept, and rx_overrun pulses for one cycle.
REQ-025 m_axis_tvalid clears after a cycle with tvalid && tready; m_axis_tdata is stable while tvalid = 1 and tready = 0.
REQ-026 SS rise mid-word: the partial RX byte is discarded (no m_axis beat), the bit counter is cleared, and the TX byte already loaded is lost with no flag.
REQ-027 SCK edges in IDLE are ignored.
REQ-028 Simultaneous s_axis fill and word load in one cycle: the load takes the old holding state (IDLE_DATA if it was empty), and the new byte is held for the next word.
REQ-029 Latency: m_axis_tvalid rises SYNC_STAGES+2 aclk cycles after the 8th SCK rise at the pin.

Reset
REQ-030 While areset = 1, at the next aclk edge: state IDLE, bit counter 0, shifters 0, holding register empty, synchroniser flops 1 for SS and 0 for SCK/MOSI.
REQ-031 Output values while areset = 1: IO1_T = 1, IO1_O = 0, s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0, error pulses 0.
REQ-032 s_axis_tready = 1 from the first cycle after areset falls.
REQ-033 Reset mid-transfer aborts it; the block then resumes only on a fresh SS fall.

Structure
REQ-034 No shared package; the state enum is local to the module.
REQ-035 One sub-module, spi_sync_edge: per-signal synchroniser plus rise/fall detect, instantiated three times.

Verification
REQ-036 Bench acts as mode-0 master at aclk/16; preload s_axis 8'hA5, master sends 8'h55 -> MISO carries A5 and m_axis delivers 55.
REQ-037 Empty holding register, master sends 8'h3C -> MISO carries 00, tx_underrun pulses once, m_axis delivers 3C.
REQ-038 Three back-to-back words under one SS, s_axis 11/22/33 and master sends C1/C2/C3 -> MISO 11, 22, 33 and m_axis C1, C2, C3 in order.
REQ-039 m_axis_tready = 0, master sends AA then BB -> m_axis holds AA, rx_overrun pulses at word 2, BB is lost, and AA transfers when tready = 1.
REQ-040 SS raised after 5 bits of 8'hF0 -> no m_axis beat, IO1_T = 1; next full word 8'h0F is received correctly.
REQ-041 areset pulsed mid-word -> all outputs reach their reset values and the next transfer, 8'h81, completes correctly.
